// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard sequencing logic:
// FSM encodings, PC source selects and the jump opcodes used by jump detection.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        JUMP_BUB = 2'd1,
        LU_STALL = 2'd2,
        MEM_WAIT = 2'd3
    } flush_state_t;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    function automatic logic is_jump_opcode(input logic [6:0] opcode);
        return (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

endpackage

// File: rtl/pipeline_flush_controller_if.sv
// Hazard inputs and pipeline control outputs of the flush controller.
// slave = the controller, master = the surrounding core (or a bench).
interface pipeline_flush_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic             jump_dec;
    logic             branch_taken_ex;
    logic             load_use_haz;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_we;
    logic             if_id_we;
    logic             ex_mem_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] flush_count;

    modport slave (
        input  jump_dec, branch_taken_ex, load_use_haz, dmem_req, dmem_ready,
        output pc_we, if_id_we, ex_mem_we, if_id_flush, id_ex_flush, pc_sel, flush_count
    );

    modport master (
        output jump_dec, branch_taken_ex, load_use_haz, dmem_req, dmem_ready,
        input  pc_we, if_id_we, ex_mem_we, if_id_flush, id_ex_flush, pc_sel, flush_count
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_flush_controller.sv
// Decode-stage hazard sequencer: stalls, flushes and redirects the front end for
// jumps, taken branches, load-use hazards and data-memory wait states.
module pipeline_flush_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned JUMP_BUBBLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_flush_controller_if.slave  bus
);

    localparam logic [2:0] BUB_INIT = 3'(JUMP_BUBBLES - 1);

    flush_state_t state, state_nxt;
    flush_state_t ret_state, ret_nxt;
    flush_state_t eff_state;
    logic [2:0]   bub_cnt, bub_nxt;
    logic         stall_now;

    logic       pc_we, if_id_we, ex_mem_we;
    logic       if_id_flush, id_ex_flush;
    logic [1:0] pc_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            bub_cnt   <= 3'd0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            bub_cnt   <= bub_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ret_nxt     = ret_state;
        bub_nxt     = bub_cnt;
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        ex_mem_we   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_sel      = PC_SEL_SEQ;
        // On the MEM_WAIT release cycle the saved state is replayed with the stall rule masked.
        eff_state   = (state == MEM_WAIT) ? ret_state : state;
        stall_now   = (state != MEM_WAIT) && bus.dmem_req && !bus.dmem_ready;

        if (rst) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            ex_mem_we   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if ((state == MEM_WAIT) && !bus.dmem_ready) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            ex_mem_we = 1'b0;
        end else if (stall_now) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            ex_mem_we = 1'b0;
            ret_nxt   = (eff_state == JUMP_BUB) ? JUMP_BUB : RUN;
            state_nxt = MEM_WAIT;
        end else if (eff_state == JUMP_BUB) begin
            // The decode slot is a flushed bubble, so jump/load-use flags are stale here.
            if (bus.branch_taken_ex) begin
                pc_sel      = PC_SEL_BRANCH;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                bub_nxt     = 3'd0;
                state_nxt   = RUN;
            end else begin
                if_id_flush = 1'b1;
                bub_nxt     = bub_cnt - 3'd1;
                state_nxt   = (bub_cnt == 3'd1) ? RUN : JUMP_BUB;
            end
        end else begin
            state_nxt = RUN;
            if (bus.branch_taken_ex) begin
                pc_sel      = PC_SEL_BRANCH;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (bus.load_use_haz && (eff_state == RUN)) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
                state_nxt   = LU_STALL;
            end else if (bus.jump_dec) begin
                pc_sel      = PC_SEL_JUMP;
                if_id_flush = 1'b1;
                if (JUMP_BUBBLES > 1) begin
                    bub_nxt   = BUB_INIT;
                    state_nxt = JUMP_BUB;
                end
            end
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.if_id_we    = if_id_we;
    assign bus.ex_mem_we   = ex_mem_we;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.pc_sel      = pc_sel;

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush && !rst),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_pipeline_flush_controller.sv
// Bench for pipeline_flush_controller: a vector table on a JUMP_BUBBLES=3 instance and
// hand sequences on a JUMP_BUBBLES=2, CNT_W=4 instance, both checked through scoreboard queues.
module tb_pipeline_flush_controller;

    typedef struct {
        logic       rst;
        logic       jd;
        logic       br;
        logic       lu;
        logic       rq;
        logic       rdy;
        logic [6:0] ctl;   // {pc_we, if_id_we, ex_mem_we, if_id_flush, id_ex_flush, pc_sel}
        int         fc;
    } vec_t;

    typedef struct {
        logic [6:0] ctl;
        int         fc;
    } exp_t;

    localparam logic [6:0] C_RST  = 7'b000_11_00;
    localparam logic [6:0] C_NORM = 7'b111_00_00;
    localparam logic [6:0] C_JMP  = 7'b111_10_01;
    localparam logic [6:0] C_BUB  = 7'b111_10_00;
    localparam logic [6:0] C_BR   = 7'b111_11_10;
    localparam logic [6:0] C_LU   = 7'b001_01_00;
    localparam logic [6:0] C_FRZ  = 7'b000_00_00;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    vec_t va[29];

    always #5 clk = ~clk;

    pipeline_flush_controller_if #(.CNT_W(16)) ifa ();
    pipeline_flush_controller_if #(.CNT_W(4))  ifb ();

    pipeline_flush_controller #(.JUMP_BUBBLES(3), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    pipeline_flush_controller #(.JUMP_BUBBLES(2), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    function automatic vec_t mk(input logic r, input logic jd, input logic br, input logic lu,
                                input logic rq, input logic rdy, input logic [6:0] ctl, input int fc);
        vec_t v;
        v.rst = r; v.jd = jd; v.br = br; v.lu = lu; v.rq = rq; v.rdy = rdy;
        v.ctl = ctl; v.fc = fc;
        return v;
    endfunction

    task automatic check_a(input string name);
        exp_t e;
        logic [6:0] got;
        got = {ifa.pc_we, ifa.if_id_we, ifa.ex_mem_we, ifa.if_id_flush, ifa.id_ex_flush, ifa.pc_sel};
        n_checks++;
        if (qa.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard A empty", name);
        end else begin
            e = qa.pop_front();
            if (got !== e.ctl) begin
                n_fail++;
                $display("FAIL %s ctl: got %b expected %b", name, got, e.ctl);
            end
            n_checks++;
            if (int'(ifa.flush_count) != e.fc || $isunknown(ifa.flush_count)) begin
                n_fail++;
                $display("FAIL %s flush_count: got %0d expected %0d", name, ifa.flush_count, e.fc);
            end
        end
    endtask

    task automatic check_b(input string name);
        exp_t e;
        logic [6:0] got;
        got = {ifb.pc_we, ifb.if_id_we, ifb.ex_mem_we, ifb.if_id_flush, ifb.id_ex_flush, ifb.pc_sel};
        n_checks++;
        if (qb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard B empty", name);
        end else begin
            e = qb.pop_front();
            if (got !== e.ctl) begin
                n_fail++;
                $display("FAIL %s ctl: got %b expected %b", name, got, e.ctl);
            end
            n_checks++;
            if (int'(ifb.flush_count) != e.fc || $isunknown(ifb.flush_count)) begin
                n_fail++;
                $display("FAIL %s flush_count: got %0d expected %0d", name, ifb.flush_count, e.fc);
            end
        end
    endtask

    task automatic step_a(input vec_t v, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_a               = v.rst;
        ifa.jump_dec        = v.jd;
        ifa.branch_taken_ex = v.br;
        ifa.load_use_haz    = v.lu;
        ifa.dmem_req        = v.rq;
        ifa.dmem_ready      = v.rdy;
        e.ctl = v.ctl;
        e.fc  = v.fc;
        qa.push_back(e);
        @(negedge clk);
        check_a(name);
    endtask

    task automatic step_b(input vec_t v, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_b               = v.rst;
        ifb.jump_dec        = v.jd;
        ifb.branch_taken_ex = v.br;
        ifb.load_use_haz    = v.lu;
        ifb.dmem_req        = v.rq;
        ifb.dmem_ready      = v.rdy;
        e.ctl = v.ctl;
        e.fc  = v.fc;
        qb.push_back(e);
        @(negedge clk);
        check_b(name);
    endtask

    initial begin
        ifa.jump_dec = 1'b1; ifa.branch_taken_ex = 1'b0; ifa.load_use_haz = 1'b0;
        ifa.dmem_req = 1'b0; ifa.dmem_ready = 1'b0;
        ifb.jump_dec = 1'b1; ifb.branch_taken_ex = 1'b0; ifb.load_use_haz = 1'b0;
        ifb.dmem_req = 1'b0; ifb.dmem_ready = 1'b0;

        //           rst jd br lu rq rdy  ctl     fc
        va[0]  = mk(1, 1, 0, 0, 0, 0, C_RST,  0);
        va[1]  = mk(1, 1, 0, 0, 0, 0, C_RST,  0);
        va[2]  = mk(0, 0, 0, 0, 0, 0, C_NORM, 0);
        va[3]  = mk(0, 1, 0, 0, 0, 0, C_JMP,  0);
        va[4]  = mk(0, 0, 0, 0, 0, 0, C_BUB,  1);
        va[5]  = mk(0, 0, 0, 0, 0, 0, C_BUB,  2);
        va[6]  = mk(0, 0, 0, 0, 0, 0, C_NORM, 3);
        va[7]  = mk(0, 1, 1, 1, 0, 0, C_BR,   3);
        va[8]  = mk(0, 0, 0, 0, 0, 0, C_NORM, 4);
        va[9]  = mk(0, 0, 0, 1, 0, 0, C_LU,   4);
        va[10] = mk(0, 0, 0, 1, 0, 0, C_NORM, 4);
        va[11] = mk(0, 0, 0, 0, 0, 0, C_NORM, 4);
        va[12] = mk(0, 0, 1, 0, 1, 0, C_FRZ,  4);
        va[13] = mk(0, 0, 1, 0, 1, 0, C_FRZ,  4);
        va[14] = mk(0, 0, 1, 0, 1, 0, C_FRZ,  4);
        va[15] = mk(0, 0, 1, 0, 1, 0, C_FRZ,  4);
        va[16] = mk(0, 0, 1, 0, 1, 1, C_BR,   4);
        va[17] = mk(0, 0, 0, 0, 0, 0, C_NORM, 5);
        va[18] = mk(0, 1, 0, 0, 0, 0, C_JMP,  5);
        va[19] = mk(1, 0, 0, 0, 0, 0, C_RST,  6);
        va[20] = mk(0, 0, 0, 0, 0, 0, C_NORM, 0);
        va[21] = mk(0, 0, 0, 1, 0, 0, C_LU,   0);
        va[22] = mk(0, 1, 0, 1, 0, 0, C_JMP,  0);
        va[23] = mk(0, 0, 0, 0, 0, 0, C_BUB,  1);
        va[24] = mk(0, 0, 0, 0, 0, 0, C_BUB,  2);
        va[25] = mk(0, 0, 0, 0, 0, 0, C_NORM, 3);
        va[26] = mk(0, 1, 0, 0, 0, 0, C_JMP,  3);
        va[27] = mk(0, 0, 1, 0, 0, 0, C_BR,   4);
        va[28] = mk(0, 0, 0, 0, 0, 0, C_NORM, 5);

        for (int i = 0; i < 29; i++) begin
            step_a(va[i], $sformatf("vecA[%0d]", i));
        end

        // Memory stall inside a jump bubble, then release and saturation on the small counter.
        step_b(mk(1, 1, 0, 0, 0, 0, C_RST,  0), "B reset0");
        step_b(mk(1, 1, 0, 0, 0, 0, C_RST,  0), "B reset1");
        step_b(mk(0, 1, 0, 0, 0, 0, C_JMP,  0), "B jump");
        step_b(mk(0, 0, 0, 0, 1, 0, C_FRZ,  1), "B bub stall0");
        step_b(mk(0, 0, 1, 0, 1, 0, C_FRZ,  1), "B bub stall1");
        step_b(mk(0, 0, 0, 0, 1, 1, C_BUB,  1), "B bub release");
        step_b(mk(0, 0, 0, 0, 0, 0, C_NORM, 2), "B run0");
        step_b(mk(0, 0, 0, 0, 0, 0, C_NORM, 2), "B run1");
        for (int i = 0; i < 20; i++) begin
            step_b(mk(0, 0, 1, 0, 0, 0, C_BR, (2 + i > 15) ? 15 : 2 + i), $sformatf("B sat[%0d]", i));
        end
        step_b(mk(0, 0, 0, 0, 0, 0, C_NORM, 15), "B saturated");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_flush_controller.md
Name: pipeline_flush_controller

Overview:
Sequencing controller for front-end hazards in the 5-stage RISC-V core, located in the decode stage. Consumes the JAL/JALR NOP-inject indication, the execute-stage taken-branch result, the load-use hazard flag and the data-memory handshake. Drives PC and pipeline-register write enables, per-stage flushes and PC source selection through a small FSM with a bubble counter. Also keeps a saturating flush-cycle performance counter.

Parameters:
JUMP_BUBBLES, 1, number of IF/ID flush cycles per JAL/JALR, range 1..7
CNT_W, 16, width of flush_count

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
jump_dec  in  1  decode holds JAL/JALR (NOP-inject from jump detection)
branch_taken_ex  in  1  execute resolved a taken branch
load_use_haz  in  1  decode source register equals rd of the load in execute
dmem_req  in  1  memory stage has an access this cycle
dmem_ready  in  1  data memory completes the access this cycle
pc_we  out  1  PC register write enable
if_id_we  out  1  IF/ID write enable
ex_mem_we  out  1  ID/EX, EX/MEM and MEM/WB write enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_flush  out  1  ID/EX loads a NOP
pc_sel  out  2  00 = PC+4, 01 = jump target, 10 = branch target
flush_count  out  CNT_W  saturating count of cycles with if_id_flush=1

Behaviour:
- State: RUN, JUMP_BUB, LU_STALL, MEM_WAIT. Registers: state, ret_state, bub_cnt[2:0], flush_count.
- Outputs are combinational from the registered state and the current inputs, with zero-cycle response.
- Reset (rst=1 at the clk edge): state=RUN, ret_state=RUN, bub_cnt=0, flush_count=0.
- While rst=1: pc_we=if_id_we=ex_mem_we=0, if_id_flush=id_ex_flush=1, pc_sel=00, flush_count does not increment.
- Reset mid-stall or mid-bubble aborts the sequence and restarts in RUN.
- Default (no event): all write enables 1, both flushes 0, pc_sel=00.
- Evaluation in RUN is strict priority, first match wins:
  1. dmem_req & ~dmem_ready: all write enables 0, both flushes 0; ret_state<=RUN; next MEM_WAIT.
  2. branch_taken_ex: pc_sel=10, if_id_flush=1, id_ex_flush=1. This overrides jump_dec and load_use_haz, which are wrong-path. Next RUN.
  3. load_use_haz: pc_we=0, if_id_we=0, id_ex_flush=1. Next LU_STALL.
  4. jump_dec: pc_sel=01, if_id_flush=1.
     - If JUMP_BUBBLES==1: next RUN.
     - Otherwise: bub_cnt<=JUMP_BUBBLES-1; next JUMP_BUB.
- LU_STALL: exactly one bubble is guaranteed; load_use_haz is ignored.
  - Apply RUN priorities 1, 2 and 4 only.
  - Next RUN, unless rule 1 fires, in which case ret_state<=RUN and next MEM_WAIT.
- JUMP_BUB:
  - Rule 1 fires: freeze; bub_cnt holds; ret_state<=JUMP_BUB; next MEM_WAIT.
  - Else branch_taken_ex: handled as RUN rule 2 (defensive); next RUN; bub_cnt<=0.
  - Else: pc_we=1, pc_sel=00, if_id_flush=1, bub_cnt<=bub_cnt-1; next RUN when bub_cnt==1.
  - jump_dec and load_use_haz are ignored (flushed slot).
- MEM_WAIT:
  - dmem_ready=0: full freeze, no flushes, all other inputs ignored.
  - dmem_ready=1 (release cycle): behave exactly as ret_state with rule 1 false, so a frozen branch or jump is redirected in the cycle the pipe advances.
- flush_count increments on every non-reset cycle with if_id_flush=1 and saturates at 2^CNT_W-1. There is no wrap.
- No combinational path from any output back to any input.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - state encodings (RUN=2'd0, JUMP_BUB=2'd1, LU_STALL=2'd2, MEM_WAIT=2'd3)
  - PC_SEL_SEQ=2'b00, PC_SEL_JUMP=2'b01, PC_SEL_BRANCH=2'b10
  - JAL/JALR opcode constants, shared with jump detection
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), used for flush_count and reusable for other performance counters.

Test Plan:
- Reset: hold rst=1 for 2 cycles with jump_dec=1 -> enables all 0, flushes 1, flush_count=0. First cycle after release with quiet inputs -> pc_we=1, pc_sel=00.
- Jump with JUMP_BUBBLES=3: jump_dec=1 for one cycle -> cycle0 pc_sel=01 and if_id_flush=1; cycles1-2 if_id_flush=1 and pc_sel=00; cycle3 back to RUN; flush_count=3.
- Branch vs jump: branch_taken_ex=1, jump_dec=1 and load_use_haz=1 together -> pc_sel=10, both flushes 1, pc_we=1, state stays RUN.
- Load-use: load_use_haz=1 for 2 cycles -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; the second cycle is ignored (LU_STALL) with enables 1.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles with branch_taken_ex=1 throughout -> 4 cycles of all enables 0. On the dmem_ready=1 cycle -> pc_sel=10, both flushes 1.
- Stall inside a jump bubble with JUMP_BUBBLES=2: memory stall in JUMP_BUB -> bub_cnt held. Release cycle -> if_id_flush=1, then RUN. Separately, with CNT_W=4 and 20 flush cycles -> flush_count saturates at 15.
